// File: rtl/stop_watch_pkg.sv
// -----------------------------------------------------------------------------
// stop_watch_pkg
//   Shared definitions for the lap stopwatch slice.
//   - sw_state_e : controller state encoding (IDLE=0, RUN=1, PAUSE=2)
//   - DIGIT_W    : width of one BCD digit
//   - BCD_MAX    : last value of a BCD digit before it wraps
//   - calc_div   : system-clock cycles per least-significant-digit tick
// -----------------------------------------------------------------------------
package stop_watch_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// -----------------------------------------------------------------------------
// bcd_digit_cnt
//   One decimal digit of the running time. Counts 0..9 and wraps to 0.
//   Ports:
//     i_Clk   : system clock
//     i_Rst   : synchronous active-high reset
//     i_fClr  : synchronous clear (stop / return to idle)
//     i_fInc  : increment enable for this cycle
//     o_Val   : current digit value, BCD
//     o_fLst  : high while the digit sits at 9 (carry-ready to the next digit)
// -----------------------------------------------------------------------------
module bcd_digit_cnt
    import stop_watch_pkg::*;
(
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_fClr,
    input  logic               i_fInc,
    output logic [DIGIT_W-1:0] o_Val,
    output logic               o_fLst
);

    logic [DIGIT_W-1:0] val_q;

    always_ff @(posedge i_Clk) begin
        if (i_Rst || i_fClr) begin
            val_q <= '0;
        end else if (i_fInc) begin
            val_q <= (val_q == BCD_MAX) ? '0 : val_q + 1'b1;
        end
    end

    assign o_Val  = val_q;
    assign o_fLst = (val_q == BCD_MAX);

endmodule

// File: rtl/lap_stop_watch.sv
// -----------------------------------------------------------------------------
// lap_stop_watch
//   Multi-lap stopwatch. A divided system-clock tick drives a chain of BCD
//   digits; lap times are kept in a circular register buffer and browsed with
//   the recall button.
//   Parameters:
//     CLK_HZ, TICK_HZ : system clock and least-significant-digit rate
//     NUM_DIGITS      : BCD digits in the running time and in each lap (1..8)
//     LAP_DEPTH       : number of lap slots (1..16)
//   Ports:
//     i_Clk, i_Rst    : clock, synchronous active-high reset
//     i_fStart        : start/pause button, active-low
//     i_fStop         : stop/clear button, active-low
//     i_fRecord       : lap-record button, active-low
//     i_fRecall       : lap-browse button, active-low
//     o_Cur           : running time, BCD, digit 0 in bits [3:0]
//     o_Lap           : lap slot selected by o_LapIdx, BCD
//     o_LapIdx        : slot shown on o_Lap
//     o_LapCnt        : number of valid laps stored
//     o_State         : IDLE=0, RUN=1, PAUSE=2
//     o_fOvf          : sticky overflow flag, cleared by stop or reset
// -----------------------------------------------------------------------------
module lap_stop_watch
    import stop_watch_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned TICK_HZ    = 10,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned LAP_DEPTH  = 4
) (
    input  logic                                       i_Clk,
    input  logic                                       i_Rst,
    input  logic                                       i_fStart,
    input  logic                                       i_fStop,
    input  logic                                       i_fRecord,
    input  logic                                       i_fRecall,
    output logic [DIGIT_W*NUM_DIGITS-1:0]              o_Cur,
    output logic [DIGIT_W*NUM_DIGITS-1:0]              o_Lap,
    output logic [((LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1)-1:0] o_LapIdx,
    output logic [$clog2(LAP_DEPTH+1)-1:0]             o_LapCnt,
    output logic [1:0]                                 o_State,
    output logic                                       o_fOvf
);

    localparam int unsigned DIV   = calc_div(CLK_HZ, TICK_HZ);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CUR_W = DIGIT_W * NUM_DIGITS;
    localparam int unsigned IDX_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(LAP_DEPTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LAP_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LAP_DEPTH);

    if (DIV < 2 || NUM_DIGITS < 1 || NUM_DIGITS > 8 ||
        LAP_DEPTH < 1 || LAP_DEPTH > 16) begin : g_param_check
        $error("lap_stop_watch: parameter out of range");
    end

    // ---------------------------------------------------------------------
    // Button edge detection: {start, stop, record, recall}, active-low.
    // Two register stages so the press pulse comes from registered state only.
    // ---------------------------------------------------------------------
    logic [3:0] btn_cur;
    logic [3:0] btn_prev;
    logic [3:0] press;
    logic       start_p;
    logic       stop_p;
    logic       rec_p;
    logic       rcl_p;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            btn_cur  <= '1;
            btn_prev <= '1;
        end else begin
            btn_cur  <= {i_fStart, i_fStop, i_fRecord, i_fRecall};
            btn_prev <= btn_cur;
        end
    end

    assign press   = btn_prev & ~btn_cur;
    assign start_p = press[3];
    assign stop_p  = press[2];
    assign rec_p   = press[1];
    assign rcl_p   = press[0];

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    sw_state_e state_q;
    sw_state_e state_d;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_p && !stop_p) state_d = RUN;
            end
            RUN: begin
                if (stop_p)       state_d = IDLE;
                else if (start_p) state_d = PAUSE;
            end
            PAUSE: begin
                if (stop_p)       state_d = IDLE;
                else if (start_p) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stop is the only way into IDLE, so it doubles as the datapath clear.
    logic clr;
    assign clr = stop_p;

    // ---------------------------------------------------------------------
    // Tick divider
    // ---------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic             tick;

    assign tick = (state_q == RUN) && (div_q == DIV_LAST);

    always_ff @(posedge i_Clk) begin
        if (i_Rst || clr) begin
            div_q <= '0;
        end else begin
            case (state_q)
                RUN:     div_q <= tick ? '0 : div_q + 1'b1;
                PAUSE:   div_q <= div_q;
                default: div_q <= '0;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // BCD digit chain
    // ---------------------------------------------------------------------
    logic [CUR_W-1:0]      cur;
    logic [NUM_DIGITS-1:0] lst;
    logic [NUM_DIGITS:0]   carry;

    always_comb begin
        carry[0] = tick;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            carry[k+1] = carry[k] & lst[k];
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        bcd_digit_cnt u_digit (
            .i_Clk  (i_Clk),
            .i_Rst  (i_Rst),
            .i_fClr (clr),
            .i_fInc (carry[k]),
            .o_Val  (cur[k*DIGIT_W +: DIGIT_W]),
            .o_fLst (lst[k])
        );
    end

    logic ovf_q;

    always_ff @(posedge i_Clk) begin
        if (i_Rst || clr) begin
            ovf_q <= 1'b0;
        end else if (carry[NUM_DIGITS]) begin
            ovf_q <= 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Lap buffer
    // ---------------------------------------------------------------------
    logic [CUR_W-1:0] laps [LAP_DEPTH];
    logic [IDX_W-1:0] wr_ptr_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] oldest;
    logic [IDX_W-1:0] newest;
    logic [IDX_W-1:0] older;
    logic             rec_en;
    logic             rcl_en;

    // Record takes precedence over recall only when it actually records.
    assign rec_en = rec_p && !stop_p && (state_q == RUN);
    assign rcl_en = rcl_p && !stop_p && !rec_en &&
                    (state_q != IDLE) && (cnt_q != '0);

    // Until the buffer fills, slot 0 holds the oldest lap; afterwards the
    // write pointer points at it.
    assign oldest = (cnt_q == CNT_FULL) ? wr_ptr_q : '0;
    assign newest = (wr_ptr_q == '0) ? IDX_LAST : wr_ptr_q - 1'b1;
    assign older  = (idx_q == oldest) ? newest :
                    (idx_q == '0)     ? IDX_LAST : idx_q - 1'b1;

    always_ff @(posedge i_Clk) begin
        if (i_Rst || clr) begin
            for (int unsigned i = 0; i < LAP_DEPTH; i++) begin
                laps[i] <= '0;
            end
            wr_ptr_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
        end else if (rec_en) begin
            laps[wr_ptr_q] <= cur;
            wr_ptr_q       <= (wr_ptr_q == IDX_LAST) ? '0 : wr_ptr_q + 1'b1;
            idx_q          <= wr_ptr_q;
            if (cnt_q != CNT_FULL) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (rcl_en) begin
            idx_q <= older;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign o_Cur    = cur;
    assign o_Lap    = laps[idx_q];
    assign o_LapIdx = idx_q;
    assign o_LapCnt = cnt_q;
    assign o_State  = state_q;
    assign o_fOvf   = ovf_q;

endmodule

// File: tb/tb_lap_stop_watch.sv
// -----------------------------------------------------------------------------
// tb_lap_stop_watch
//   Self-checking bench for lap_stop_watch (CLK_HZ=20, TICK_HZ=2, two digits,
//   three lap slots). Elapsed time is modelled as a plain integer count and the
//   lap history as a list of every value recorded since the last clear.
// -----------------------------------------------------------------------------
module tb_lap_stop_watch;

    localparam int ND   = 2;
    localparam int LD   = 3;
    localparam int DIV  = 10;
    localparam int MAXT = 100;

    // Active-low button masks, bit order {start, stop, record, recall}
    localparam logic [3:0] NONE = 4'b1111;
    localparam logic [3:0] B_S  = 4'b0111;
    localparam logic [3:0] B_P  = 4'b1011;
    localparam logic [3:0] B_R  = 4'b1101;
    localparam logic [3:0] B_C  = 4'b1110;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b_start = 1'b1;
    logic       b_stop = 1'b1;
    logic       b_rec = 1'b1;
    logic       b_rcl = 1'b1;
    logic [7:0] o_Cur;
    logic [7:0] o_Lap;
    logic [1:0] o_LapIdx;
    logic [1:0] o_LapCnt;
    logic [1:0] o_State;
    logic       o_fOvf;

    always #5 clk = ~clk;

    lap_stop_watch #(
        .CLK_HZ     (20),
        .TICK_HZ    (2),
        .NUM_DIGITS (ND),
        .LAP_DEPTH  (LD)
    ) dut (
        .i_Clk     (clk),
        .i_Rst     (rst),
        .i_fStart  (b_start),
        .i_fStop   (b_stop),
        .i_fRecord (b_rec),
        .i_fRecall (b_rcl),
        .o_Cur     (o_Cur),
        .o_Lap     (o_Lap),
        .o_LapIdx  (o_LapIdx),
        .o_LapCnt  (o_LapCnt),
        .o_State   (o_State),
        .o_fOvf    (o_fOvf)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    int         m_time;   // elapsed ticks modulo MAXT
    int         m_phase;  // cycles into the current tick period
    int         m_state;  // 0 idle, 1 run, 2 pause
    logic       m_ovf;
    int         recs[$];  // every lap recorded since the last clear
    int         m_age;    // 0 = newest lap shown, 1 = next older, ...
    logic [3:0] h1;       // button levels one and two samples back
    logic [3:0] h2;

    function automatic logic [4*ND-1:0] to_bcd(input int v);
        logic [4*ND-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < ND; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_clear();
        m_time  = 0;
        m_phase = 0;
        m_state = 0;
        m_ovf   = 1'b0;
        recs.delete();
        m_age   = 0;
    endtask

    task automatic model_step(input logic r, input logic [3:0] b);
        logic [3:0] p;
        logic tick;
        int cnt;
        if (r) begin
            model_clear();
            h1 = NONE;
            h2 = NONE;
            return;
        end
        p    = h2 & ~h1;
        tick = (m_state == 1) && (m_phase == DIV - 1);
        cnt  = (recs.size() < LD) ? recs.size() : LD;
        if (p[2]) begin
            model_clear();
        end else begin
            if (p[1] && m_state == 1) begin
                recs.push_back(m_time);
                m_age = 0;
            end else if (p[0] && m_state != 0 && cnt > 0) begin
                m_age = (m_age + 1) % cnt;
            end
            if (m_state == 1)      m_phase = tick ? 0 : m_phase + 1;
            else if (m_state == 0) m_phase = 0;
            if (tick) begin
                m_time++;
                if (m_time == MAXT) begin
                    m_time = 0;
                    m_ovf  = 1'b1;
                end
            end
            if (p[3]) m_state = (m_state == 1) ? 2 : 1;
        end
        h2 = h1;
        h1 = b;
    endtask

    function automatic logic [22:0] model_pack();
        int n;
        int cnt;
        int pos;
        logic [7:0] lap;
        logic [1:0] idx;
        n   = recs.size();
        cnt = (n < LD) ? n : LD;
        lap = '0;
        idx = '0;
        if (n > 0) begin
            pos = n - 1 - m_age;
            lap = to_bcd(recs[pos]);
            idx = 2'(pos % LD);
        end
        return {to_bcd(m_time), 2'(m_state), 2'(cnt), idx, lap, m_ovf};
    endfunction

    // ---------------- check helpers ----------------
    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_model();
        logic [22:0] e;
        logic [22:0] g;
        e = model_pack();
        g = {o_Cur, o_State, o_LapCnt, o_LapIdx, o_Lap, o_fOvf};
        tests++;
        if (g !== e) begin
            fails++;
            $display("FAIL model @%0t: got cur=%h st=%0d cnt=%0d idx=%0d lap=%h ovf=%b, expected cur=%h st=%0d cnt=%0d idx=%0d lap=%h ovf=%b",
                     $time, g[22:15], g[14:13], g[12:11], g[10:9], g[8:1], g[0],
                     e[22:15], e[14:13], e[12:11], e[10:9], e[8:1], e[0]);
        end
    endtask

    // Drive one cycle of inputs, step the model at the edge, check at negedge.
    task automatic step(input logic r, input logic [3:0] b);
        rst = r;
        {b_start, b_stop, b_rec, b_rcl} = b;
        @(posedge clk);
        model_step(r, b);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, NONE);
    endtask

    task automatic press(input logic [3:0] b, input int k);
        step(1'b0, b);
        idle(k);
    endtask

    task automatic run_until(input logic [7:0] target, input int budget, input string name);
        int n;
        n = 0;
        while (o_Cur !== target && n < budget) begin
            step(1'b0, NONE);
            n++;
        end
        check_eq(name, 32'(o_Cur), 32'(target));
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic       rst;
        logic [3:0] btn;
        int         hold;
        logic [7:0] cur;
        logic [1:0] st;
        logic [1:0] cnt;
        logic [1:0] idx;
        logic [7:0] lap;
        logic       ovf;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [3:0] b;
        logic       r;

        tbl[0] = '{1'b1, NONE, 2,   8'h00, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0};
        tbl[1] = '{1'b0, B_S,  255, 8'h25, 2'd1, 2'd0, 2'd0, 8'h00, 1'b0};
        tbl[2] = '{1'b0, B_R,  3,   8'h25, 2'd1, 2'd1, 2'd0, 8'h25, 1'b0};
        tbl[3] = '{1'b0, B_S,  50,  8'h26, 2'd2, 2'd1, 2'd0, 8'h25, 1'b0};
        tbl[4] = '{1'b0, B_C,  3,   8'h26, 2'd2, 2'd1, 2'd0, 8'h25, 1'b0};
        tbl[5] = '{1'b0, B_S,  20,  8'h27, 2'd1, 2'd1, 2'd0, 8'h25, 1'b0};
        tbl[6] = '{1'b0, B_R,  2,   8'h28, 2'd1, 2'd2, 2'd1, 8'h28, 1'b0};
        tbl[7] = '{1'b0, B_C,  2,   8'h28, 2'd1, 2'd2, 2'd0, 8'h25, 1'b0};
        tbl[8] = '{1'b0, B_P,  2,   8'h00, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0};

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].rst, tbl[i].btn);
            idle(tbl[i].hold);
            check_eq($sformatf("vec%0d", i),
                     32'({o_Cur, o_State, o_LapCnt, o_LapIdx, o_Lap, o_fOvf}),
                     32'({tbl[i].cur, tbl[i].st, tbl[i].cnt, tbl[i].idx, tbl[i].lap, tbl[i].ovf}));
        end

        // Pause keeps the partial tick
        press(B_S, 15);
        check_eq("pause_pre", 32'(o_Cur), 32'h01);
        press(B_S, 100);
        check_eq("pause_hold", 32'({o_State, o_Cur}), 32'({2'd2, 8'h01}));
        press(B_S, 8);
        check_eq("pause_resume", 32'({o_State, o_Cur}), 32'({2'd1, 8'h02}));

        // Lap overwrite and recall wrap
        press(B_P, 2);
        press(B_S, 2);
        run_until(8'h03, 100, "wait03");
        press(B_R, 1);
        run_until(8'h07, 100, "wait07");
        press(B_R, 1);
        run_until(8'h12, 100, "wait12");
        press(B_R, 1);
        run_until(8'h20, 100, "wait20");
        press(B_R, 1);
        check_eq("lap_full", 32'({o_LapCnt, o_LapIdx, o_Lap}), 32'({2'd3, 2'd0, 8'h20}));
        press(B_C, 1);
        check_eq("recall1", 32'(o_Lap), 32'h12);
        press(B_C, 1);
        check_eq("recall2", 32'(o_Lap), 32'h07);
        press(B_C, 1);
        check_eq("recall3", 32'(o_Lap), 32'h20);

        // Overflow
        run_until(8'h99, 1100, "wait99");
        check_eq("ovf_before", 32'(o_fOvf), 32'h0);
        run_until(8'h00, 12, "wrap00");
        check_eq("ovf_set", 32'(o_fOvf), 32'h1);
        press(B_P, 2);
        check_eq("ovf_stop", 32'({o_fOvf, o_State}), 32'({1'b0, 2'd0}));

        // Stop beats start; start+record records then pauses
        press(B_S, 2);
        idle(30);
        press(B_S & B_P, 2);
        check_eq("stop_start", 32'({o_State, o_Cur}), 32'({2'd0, 8'h00}));
        press(B_S, 2);
        run_until(8'h04, 60, "wait04");
        press(B_S & B_R, 2);
        check_eq("start_rec", 32'({o_State, o_LapCnt, o_Lap, o_Cur}),
                 32'({2'd2, 2'd1, 8'h04, 8'h04}));

        // Reset mid-run, then recall with no laps
        press(B_S, 2);
        idle(15);
        press(B_R, 1);
        step(1'b1, NONE);
        check_eq("rst_mid", 32'({o_Cur, o_State, o_LapCnt, o_LapIdx, o_Lap, o_fOvf}), 32'h0);
        press(B_S, 3);
        press(B_C, 2);
        check_eq("rcl_empty", 32'({o_State, o_LapCnt, o_LapIdx}), 32'({2'd1, 2'd0, 2'd0}));

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r    = ($urandom_range(0, 299) == 0);
            b[3] = ($urandom_range(0, 9) != 0);
            b[2] = ($urandom_range(0, 59) != 0);
            b[1] = ($urandom_range(0, 5) != 0);
            b[0] = ($urandom_range(0, 4) != 0);
            step(r, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog: time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
